// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV64I-subset processor.
// Every instruction completes in one clk cycle: fetch, decode, execute,
// memory access and register write-back.
//
// Ports
//   clk        : the only clock; all state changes on its rising edge
//   rst        : asynchronous, active-low reset (clears pc and regs)
//   dbg_wr_en  : instruction-memory write strobe used for program loading
//   dbg_addr   : byte address of the instruction word to write
//   dbg_instr  : instruction word to write
//
// Observable state (hierarchical): pc, regs[0:31], imem[0:63], dmem[0:31].
// imem is 64 words, addressed by byte-address bits [7:2].
// dmem is 32 doublewords, addressed by byte-address bits [7:3].
// Both wrap modulo 256 bytes, and neither is cleared by reset.
module cpu_core #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dbg_wr_en,
  input  logic [XLEN-1:0]               dbg_addr,
  input  logic [INSTRUCTION_LENGTH-1:0] dbg_instr
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_DOUBLE = 3'b011;

  logic [INSTRUCTION_LENGTH-1:0] imem [0:63];
  logic [XLEN-1:0]               dmem [0:31];
  logic [XLEN-1:0]               regs [0:31];
  logic [XLEN-1:0]               pc;

  // Immediate sign extension for the RISC-V formats.
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext13(input logic [12:0] v);
    return {{(XLEN-13){v[12]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext21(input logic [20:0] v);
    return {{(XLEN-21){v[20]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // Integer ALU shared by register-register and register-immediate forms.
  // alt selects SUB over ADD and SRA over SRL; shifts use the low 6 bits of b.
  function automatic logic [XLEN-1:0] alu(input logic            alt,
                                          input logic [2:0]      f3,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [5:0]             sh;
    a_s = a;
    b_s = b;
    sh  = b[5:0];
    case (f3)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << sh;
      3'b010:  alu = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      3'b011:  alu = {{(XLEN-1){1'b0}}, (a < b)};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned(a_s >>> sh) : (a >> sh);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Fetch and decode
  logic [INSTRUCTION_LENGTH-1:0] instr;
  logic [6:0]                    opcode;
  logic [4:0]                    rd;
  logic [4:0]                    rs1;
  logic [4:0]                    rs2;
  logic [2:0]                    funct3;
  logic [6:0]                    funct7;

  assign instr  = imem[pc[7:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = sext12(instr[31:20]);
  assign imm_s = sext12({instr[31:25], instr[11:7]});
  assign imm_b = sext13({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
  assign imm_u = sext32({instr[31:12], 12'h000});
  assign imm_j = sext21({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});

  // Register reads see the value before this cycle's write-back.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  // Execute
  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        addr_i;
  logic [XLEN-1:0]        addr_s;
  logic                   br_valid;
  logic                   br_taken;
  logic                   imm_ok;
  logic                   reg_ok;

  assign rs1_s    = rs1_val;
  assign rs2_s    = rs2_val;
  assign pc_plus4 = pc + XLEN'(4);
  assign addr_i   = rs1_val + imm_i;   // load address and JALR target
  assign addr_s   = rs1_val + imm_s;   // store address

  // Branch decode: funct3 010/011 are not branches and fall through as NOPs.
  always_comb begin
    br_valid = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = (rs1_s < rs2_s);
      3'b101:  br_taken = !(rs1_s < rs2_s);
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = !(rs1_val < rs2_val);
      default: br_valid = 1'b0;
    endcase
  end

  // Only the RV64I encodings of the shift/arith forms are accepted; other
  // funct7 values (e.g. the M extension) execute as NOPs.
  assign imm_ok = (funct3 == 3'b001) ? (instr[31:26] == 6'b000000) :
                  (funct3 == 3'b101) ? ((instr[31:26] == 6'b000000) ||
                                        (instr[31:26] == 6'b010000)) :
                  1'b1;
  assign reg_ok = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) &&
                   ((funct3 == 3'b000) || (funct3 == 3'b101)));

  logic            wb_en;
  logic [XLEN-1:0] wb_data;
  logic            mem_we;
  logic [XLEN-1:0] next_pc;

  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    mem_we  = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OP_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OP_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          next_pc = {addr_i[XLEN-1:1], 1'b0};
        end
      end
      OP_BRANCH: begin
        if (br_valid && br_taken) next_pc = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == F3_DOUBLE) begin
          wb_en   = 1'b1;
          wb_data = dmem[addr_i[7:3]];
        end
      end
      OP_STORE: begin
        if (funct3 == F3_DOUBLE) mem_we = rst;
      end
      OP_IMM: begin
        if (imm_ok) begin
          wb_en   = 1'b1;
          wb_data = alu((funct3 == 3'b101) && instr[30], funct3, rs1_val, imm_i);
        end
      end
      OP_REG: begin
        if (reg_ok) begin
          wb_en   = 1'b1;
          wb_data = alu(instr[30], funct3, rs1_val, rs2_val);
        end
      end
      default: ;  // FENCE, all-zero word and unsupported opcodes
    endcase
  end

  // State update at the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (rd != 5'd0)) begin
      regs[rd] <= wb_data;
    end
  end

  // Memories carry no reset; the debug port loads imem even while in reset.
  always_ff @(posedge clk) begin
    if (dbg_wr_en) imem[dbg_addr[7:2]] <= dbg_instr;
  end

  always_ff @(posedge clk) begin
    if (mem_we) dmem[addr_s[7:3]] <= rs2_val;
  end

  logic unused_bits;
  assign unused_bits = ^{dbg_addr[XLEN-1:8], dbg_addr[1:0],
                         addr_s[XLEN-1:8], addr_s[2:0]};

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core: a table of single-instruction records executed as
// one program, plus hand-written sequences for reset, branch/jump loops,
// imem wrap-around and same-cycle debug writes.
module tb_cpu_core;

  localparam int XLEN = 64;
  localparam int IL   = 32;

  localparam logic [6:0]  OPI  = 7'b0010011;
  localparam logic [31:0] SKIP = 32'h00100C93;  // ADDI x25,x0,1
  localparam logic [31:0] NOP  = 32'h00000013;  // ADDI x0,x0,0

  logic            clk = 1'b0;
  logic            rst;
  logic            dbg_wr_en;
  logic [XLEN-1:0] dbg_addr;
  logic [IL-1:0]   dbg_instr;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_core #(.XLEN(XLEN), .INSTRUCTION_LENGTH(IL)) dut (
    .clk       (clk),
    .rst       (rst),
    .dbg_wr_en (dbg_wr_en),
    .dbg_addr  (dbg_addr),
    .dbg_instr (dbg_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        is_mem;   // 1: check dmem[idx], 0: check regs[idx]
    logic [4:0]  idx;
    logic [63:0] exp;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [63:0] addr, input logic [31:0] instr,
                     input logic is_mem, input logic [4:0] idx,
                     input logic [63:0] exp, input logic [63:0] exp_pc);
    vec_t v;
    v.addr = addr; v.instr = instr; v.is_mem = is_mem;
    v.idx = idx; v.exp = exp; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ri(input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, OPI};
  endfunction

  function automatic logic [31:0] rr(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] ld(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm, rs1, 3'b011, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                     input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // All tasks below are entered and left on a falling clk edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic dbg_write(input logic [63:0] addr, input logic [31:0] word);
    dbg_wr_en = 1'b1;
    dbg_addr  = addr;
    dbg_instr = word;
    @(negedge clk);
    dbg_wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    dbg_wr_en = 1'b0;
    dbg_addr  = '0;
    dbg_instr = '0;

    // Main program table: each record is one executed instruction.
    add(64'd0,   ri(3'b000, 5'd1, 5'd0, 12'h005),        1'b0, 5'd1,  64'd5, 64'd4);
    add(64'd4,   ri(3'b000, 5'd2, 5'd0, 12'hFFD),        1'b0, 5'd2,  64'hFFFFFFFFFFFFFFFD, 64'd8);
    add(64'd8,   rr(7'h00, 3'b000, 5'd3, 5'd1, 5'd2),    1'b0, 5'd3,  64'd2, 64'd12);
    add(64'd12,  rr(7'h20, 3'b000, 5'd4, 5'd1, 5'd2),    1'b0, 5'd4,  64'd8, 64'd16);
    add(64'd16,  rr(7'h00, 3'b010, 5'd5, 5'd2, 5'd1),    1'b0, 5'd5,  64'd1, 64'd20);
    add(64'd20,  rr(7'h00, 3'b011, 5'd6, 5'd1, 5'd2),    1'b0, 5'd6,  64'd1, 64'd24);
    add(64'd24,  rr(7'h00, 3'b100, 5'd7, 5'd1, 5'd2),    1'b0, 5'd7,  64'hFFFFFFFFFFFFFFF8, 64'd28);
    add(64'd28,  rr(7'h00, 3'b110, 5'd8, 5'd1, 5'd2),    1'b0, 5'd8,  64'hFFFFFFFFFFFFFFFD, 64'd32);
    add(64'd32,  rr(7'h00, 3'b111, 5'd9, 5'd1, 5'd2),    1'b0, 5'd9,  64'd5, 64'd36);
    add(64'd36,  ri(3'b001, 5'd10, 5'd1, 12'h03C),       1'b0, 5'd10, 64'h5000000000000000, 64'd40);
    add(64'd40,  ri(3'b101, 5'd11, 5'd2, 12'h03C),       1'b0, 5'd11, 64'h000000000000000F, 64'd44);
    add(64'd44,  ri(3'b101, 5'd12, 5'd2, 12'h401),       1'b0, 5'd12, 64'hFFFFFFFFFFFFFFFE, 64'd48);
    add(64'd48,  rr(7'h00, 3'b001, 5'd13, 5'd1, 5'd1),   1'b0, 5'd13, 64'h00000000000000A0, 64'd52);
    add(64'd52,  rr(7'h20, 3'b101, 5'd14, 5'd7, 5'd1),   1'b0, 5'd14, 64'hFFFFFFFFFFFFFFFF, 64'd56);
    add(64'd56,  rr(7'h00, 3'b101, 5'd15, 5'd2, 5'd4),   1'b0, 5'd15, 64'h00FFFFFFFFFFFFFF, 64'd60);
    add(64'd60,  ri(3'b010, 5'd16, 5'd2, 12'hFFE),       1'b0, 5'd16, 64'd1, 64'd64);
    add(64'd64,  ri(3'b011, 5'd17, 5'd1, 12'hFFF),       1'b0, 5'd17, 64'd1, 64'd68);
    add(64'd68,  ri(3'b100, 5'd18, 5'd1, 12'hFFF),       1'b0, 5'd18, 64'hFFFFFFFFFFFFFFFA, 64'd72);
    add(64'd72,  ri(3'b110, 5'd19, 5'd1, 12'h030),       1'b0, 5'd19, 64'h35, 64'd76);
    add(64'd76,  ri(3'b111, 5'd20, 5'd2, 12'h0F0),       1'b0, 5'd20, 64'hF0, 64'd80);
    add(64'd80,  {20'h80000, 5'd21, 7'b0110111},         1'b0, 5'd21, 64'hFFFFFFFF80000000, 64'd84);
    add(64'd84,  {20'h00001, 5'd22, 7'b0010111},         1'b0, 5'd22, 64'h1054, 64'd88);
    add(64'd88,  sd(5'd3, 5'd0, 12'h008),                1'b1, 5'd1,  64'd2, 64'd92);
    add(64'd92,  ld(5'd23, 5'd0, 12'h008),               1'b0, 5'd23, 64'd2, 64'd96);
    add(64'd96,  sd(5'd2, 5'd10, 12'hFF8),               1'b1, 5'd31, 64'hFFFFFFFFFFFFFFFD, 64'd100);
    add(64'd100, ld(5'd24, 5'd0, 12'h0FD),               1'b0, 5'd24, 64'hFFFFFFFFFFFFFFFD, 64'd104);
    add(64'd104, br(3'b001, 5'd1, 5'd2, 13'h008),        1'b0, 5'd1,  64'd5, 64'd112);
    add(64'd112, br(3'b100, 5'd2, 5'd1, 13'h008),        1'b0, 5'd1,  64'd5, 64'd120);
    add(64'd120, br(3'b110, 5'd2, 5'd1, 13'h008),        1'b0, 5'd1,  64'd5, 64'd124);
    add(64'd124, br(3'b101, 5'd2, 5'd1, 13'h008),        1'b0, 5'd1,  64'd5, 64'd128);
    add(64'd128, br(3'b111, 5'd2, 5'd1, 13'h008),        1'b0, 5'd1,  64'd5, 64'd136);
    add(64'd136, br(3'b000, 5'd1, 5'd2, 13'h008),        1'b0, 5'd1,  64'd5, 64'd140);
    add(64'd140, jal(5'd26, 21'h000008),                 1'b0, 5'd26, 64'd144, 64'd148);
    add(64'd148, {12'h0A0, 5'd9, 3'b000, 5'd27, 7'b1100111}, 1'b0, 5'd27, 64'd152, 64'd164);
    add(64'd164, ri(3'b000, 5'd0, 5'd0, 12'h007),        1'b0, 5'd0,  64'd0, 64'd168);
    add(64'd168, 32'h0120000F,                           1'b0, 5'd1,  64'd5, 64'd172);
    add(64'd172, rr(7'h01, 3'b000, 5'd29, 5'd1, 5'd1),   1'b0, 5'd29, 64'd0, 64'd176);
    add(64'd176, 32'h00000000,                           1'b0, 5'd25, 64'd0, 64'd180);
    add(64'd180, jal(5'd0, 21'h1FFF4C),                  1'b0, 5'd0,  64'd0, 64'd0);

    // Reset state, and debug loading while held in reset.
    #1;
    check("reset_pc", dut.pc, 64'd0);
    check("reset_x5", dut.regs[5], 64'd0);
    @(negedge clk);
    dbg_write(64'd0, 32'h00003023);
    dbg_write(64'd4, 32'h0120000F);
    dbg_write(64'd8, 32'h00003003);
    check("imem0", {32'd0, dut.imem[0]}, 64'h00003023);
    check("imem1", {32'd0, dut.imem[1]}, 64'h0120000F);
    check("imem2", {32'd0, dut.imem[2]}, 64'h00003003);
    check("pc_held_in_reset", dut.pc, 64'd0);

    // Smoke run: SD x0, FENCE, LD x0.
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("smoke_pc%0d", i), dut.pc, 64'(4 * i));
      check($sformatf("smoke_x0_%0d", i), dut.regs[0], 64'd0);
      if (i == 1) check("smoke_dmem0", dut.dmem[0], 64'd0);
    end

    // Main program from the table.
    rst = 1'b0;
    #1;
    check("reset_again_pc", dut.pc, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 64; i++) dbg_write(64'(i * 4), SKIP);
    foreach (vecs[i]) dbg_write(vecs[i].addr, vecs[i].instr);
    rst = 1'b1;
    foreach (vecs[i]) begin
      check($sformatf("pc_before@%0d", vecs[i].addr), dut.pc, vecs[i].addr);
      step();
      check($sformatf("pc_after@%0d", vecs[i].addr), dut.pc, vecs[i].exp_pc);
      if (vecs[i].is_mem)
        check($sformatf("dmem%0d@%0d", vecs[i].idx, vecs[i].addr),
              dut.dmem[vecs[i].idx], vecs[i].exp);
      else
        check($sformatf("x%0d@%0d", vecs[i].idx, vecs[i].addr),
              dut.regs[vecs[i].idx], vecs[i].exp);
    end
    check("skipped_words_x25", dut.regs[25], 64'd0);

    // Asynchronous reset between edges mid-program.
    step();
    check("rerun_x1", dut.regs[1], 64'd5);
    #2 rst = 1'b0;
    #1;
    check("async_pc", dut.pc, 64'd0);
    check("async_x1", dut.regs[1], 64'd0);
    check("async_x3", dut.regs[3], 64'd0);
    check("async_dmem1", dut.dmem[1], 64'd2);
    check("async_dmem31", dut.dmem[31], 64'hFFFFFFFFFFFFFFFD);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("restart_pc", dut.pc, 64'd4);
    check("restart_x1", dut.regs[1], 64'd5);

    // BEQ over a word, then JAL back to 0.
    rst = 1'b0;
    @(negedge clk);
    dbg_write(64'd0, br(3'b000, 5'd0, 5'd0, 13'h008));
    dbg_write(64'd4, SKIP);
    dbg_write(64'd8, jal(5'd1, 21'h1FFFF8));
    rst = 1'b1;
    step();
    check("beq_pc", dut.pc, 64'd8);
    step();
    check("jal_pc", dut.pc, 64'd0);
    check("jal_x1", dut.regs[1], 64'd12);
    check("beq_skip_x25", dut.regs[25], 64'd0);

    // imem wrap: 63 NOPs plus an incrementer at word 0.
    rst = 1'b0;
    @(negedge clk);
    dbg_write(64'd0, ri(3'b000, 5'd5, 5'd5, 12'h001));
    for (int i = 1; i < 64; i++) dbg_write(64'(i * 4), NOP);
    rst = 1'b1;
    repeat (64) step();
    check("wrap_pc256", dut.pc, 64'd256);
    check("wrap_x5_first", dut.regs[5], 64'd1);
    step();
    check("wrap_pc260", dut.pc, 64'd260);
    check("wrap_x5_second", dut.regs[5], 64'd2);

    // A debug write to the word being fetched only takes effect next cycle.
    dbg_write(64'd4, ri(3'b000, 5'd6, 5'd0, 12'h007));
    check("samecycle_pc", dut.pc, 64'd264);
    check("samecycle_x6_old", dut.regs[6], 64'd0);
    check("samecycle_imem1", {32'd0, dut.imem[1]}, {32'd0, ri(3'b000, 5'd6, 5'd0, 12'h007)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the data path, register, PC and dbg_addr width.
REQ-002 Parameter INSTRUCTION_LENGTH, default XLEN/2 (32), SHALL set the instruction and dbg_instr width.
REQ-003 clk  input  1  SHALL be the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 dbg_wr_en  input  1  SHALL be the instruction-memory write strobe for program loading.
REQ-006 dbg_addr  input  XLEN  SHALL be the byte address of the instruction word to write.
REQ-007 dbg_instr  input  INSTRUCTION_LENGTH  SHALL be the instruction word to write.
REQ-008 The module SHALL have no other ports; state is observed hierarchically via internal signals pc, regs[0:31], imem[0:63] and dmem[0:31].

Function
REQ-009 Core SHALL be a single-cycle RV64I-subset processor: fetch, decode, execute, memory and writeback complete in one clk cycle.
REQ-010 imem SHALL be 64 x 32-bit words, indexed by address bits [7:2]; upper bits ignored, so addresses wrap modulo 256 bytes.
REQ-011 On a rising clk with dbg_wr_en=1, imem[dbg_addr[7:2]] SHALL take dbg_instr; debug writes SHALL be accepted whether rst is asserted or not.
REQ-012 Fetch SHALL read imem[pc[7:2]] combinationally; a same-cycle debug write to that word is seen by fetch only from the next cycle.
REQ-013 dmem SHALL be 32 x 64-bit doublewords, indexed by effective address bits [7:3]; bits [2:0] ignored (no misalignment trap).
REQ-014 SD SHALL write rs2 to dmem at rs1+sext(imm_S) on the rising edge; LD SHALL read combinationally and write rd on the same edge.
REQ-015 Supported instructions: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LD, SD, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-016 Arithmetic SHALL be XLEN-bit, wrap-around two's complement; shift amount SHALL be the low 6 bits; immediates sign-extended per RISC-V formats.
REQ-017 FENCE (opcode 0001111), all-zero words and any unsupported opcode SHALL execute as NOP: no register or memory write, pc+4.
REQ-018 regs SHALL be 32 x XLEN; x0 SHALL read 0 and writes to x0 SHALL be discarded.
REQ-019 Next pc SHALL be pc+4, except taken branch pc+sext(imm_B), JAL pc+sext(imm_J), JALR (rs1+sext(imm_I)) with bit 0 cleared; JAL/JALR write pc+4 to rd.
REQ-020 pc SHALL be a full XLEN register; only bits [7:2] address imem, so execution wraps from byte 252 to byte 0.
REQ-021 A write-back and a read of the same register in one cycle SHALL return the old value (write at edge end).

Reset
REQ-022 While rst=0, pc SHALL be 0 and all regs SHALL be 0, asynchronously; no instruction SHALL retire and dmem SHALL not be written.
REQ-023 imem and dmem contents SHALL not be cleared by reset.
REQ-024 On the first rising clk after rst goes 1, the instruction at byte address 0 SHALL execute; reset asserted mid-program SHALL abort immediately and restart from 0.

Verification
REQ-025 Hold rst=0; write SD x0,0(x0) (0x00003023) at addr 0, FENCE (0x0120000F) at 4, LD x0,0(x0) (0x00003003) at 8, one-cycle dbg_wr_en pulses -> imem[0..2] hold those words, pc stays 0.
REQ-026 Release rst to 1 after that load -> pc 0,4,8,12 on successive edges; dmem[0]=0; regs[0]=0 throughout; FENCE changes nothing.
REQ-027 Program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SD x3,8(x0); LD x4,8(x0) -> x3=2, dmem[1]=2, x4=2.
REQ-028 Program BEQ x0,x0,+8 at 0 -> pc goes 0 to 8, word at 4 never executes; JAL x1,-8 at 8 -> pc=0, x1=12.
REQ-029 Run program, assert rst=0 asynchronously between edges -> pc and regs read 0 immediately; dmem keeps stored values; rst=1 restarts at 0.
REQ-030 Fill imem with NOPs, run 64 cycles -> pc reaches 256 and fetch wraps to imem[0].
